change_dispenser: RTL and testbench

Pays out a change amount as physical coins through four coin hoppers (10, 5, 2, 1), in the opposite direction from coin acceptance. Sits downstream of the vending control logic: that logic presents the change value with a `start` strobe, and this block sequences one-hot eject pulses and confirms each coin on a drop sensor. It skips empty hoppers and reports completion or fault.

---
 rtl/change_dispenser_if.sv | 25 ++
 rtl/change_dispenser.sv | 168 ++++++++++++++++
 tb/tb_change_dispenser.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Bundles the payout request, hopper status, sensor and result signals
// exchanged between the vending controller and the change dispenser.
interface change_dispenser_if;
  logic       start;
  logic [6:0] amount;
  logic [3:0] hopper_empty;
  logic       coin_sensed;
  logic       fault_clr;
  logic [3:0] eject;
  logic       busy;
  logic       done;
  logic       fault;
  logic [6:0] remaining;
  logic [6:0] coins_paid;

  modport master (
    output start, amount, hopper_empty, coin_sensed, fault_clr,
    input  eject, busy, done, fault, remaining, coins_paid
  );

  modport slave (
    input  start, amount, hopper_empty, coin_sensed, fault_clr,
    output eject, busy, done, fault, remaining, coins_paid
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount out of four coin hoppers (10, 5, 2, 1),
// largest usable coin first, confirming each coin on the drop sensor.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start; counters hold last payout result
// S_SELECT   | choose largest non-empty denomination that fits remaining
// S_EJECT    | eject pulse held for PULSE_CYCLES, sensor pulse remembered
// S_WAIT_ACK | pulse over, waiting up to TIMEOUT_CYCLES for the sensor
// S_GAP      | GAP_CYCLES idle cycles between coins
// S_DONE     | one-cycle done pulse
// S_FAULT    | no usable hopper or sensor timeout; wait for fault_clr
module change_dispenser #(
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic            clk,
  input logic            rst,
  change_dispenser_if.slave io_bus
);

  localparam int MAX_CNT_A = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT   = (MAX_CNT_A > TIMEOUT_CYCLES) ? MAX_CNT_A : TIMEOUT_CYCLES;
  localparam int TW        = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_GAP, S_DONE, S_FAULT
  } state_t;

  state_t       r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [3:0]   r_sel, w_sel;
  logic [6:0]   r_denom, w_denom;
  logic         r_sensed, w_sensed;
  logic [6:0]   r_remaining, w_remaining;
  logic [6:0]   r_coins, w_coins;
  logic [3:0]   r_eject;
  logic         r_done, r_fault, r_busy;
  logic [3:0]   w_pick_sel;
  logic [6:0]   w_pick_val;

  // Largest denomination that fits the remaining amount and whose hopper has coins.
  always_comb begin
    w_pick_sel = 4'b0000;
    w_pick_val = 7'd0;
    if (r_remaining >= 7'd10 && !io_bus.hopper_empty[3]) begin
      w_pick_sel = 4'b1000;
      w_pick_val = 7'd10;
    end else if (r_remaining >= 7'd5 && !io_bus.hopper_empty[2]) begin
      w_pick_sel = 4'b0100;
      w_pick_val = 7'd5;
    end else if (r_remaining >= 7'd2 && !io_bus.hopper_empty[1]) begin
      w_pick_sel = 4'b0010;
      w_pick_val = 7'd2;
    end else if (r_remaining >= 7'd1 && !io_bus.hopper_empty[0]) begin
      w_pick_sel = 4'b0001;
      w_pick_val = 7'd1;
    end
  end

  // Next-state, timer and counter logic; counters update on entry to S_GAP.
  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_sel       = r_sel;
    w_denom     = r_denom;
    w_sensed    = r_sensed;
    w_remaining = r_remaining;
    w_coins     = r_coins;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_remaining = io_bus.amount;
          w_coins     = 7'd0;
          w_state     = (io_bus.amount == 7'd0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        if (w_pick_sel != 4'b0000) begin
          w_sel    = w_pick_sel;
          w_denom  = w_pick_val;
          w_sensed = 1'b0;
          w_timer  = TW'(PULSE_CYCLES - 1);
          w_state  = S_EJECT;
        end else begin
          w_state = S_FAULT;
        end
      end
      S_EJECT: begin
        if (r_timer == '0) begin
          if (r_sensed || io_bus.coin_sensed) begin
            w_remaining = r_remaining - r_denom;
            w_coins     = r_coins + 7'd1;
            w_timer     = TW'(GAP_CYCLES - 1);
            w_state     = S_GAP;
          end else begin
            w_timer = TW'(TIMEOUT_CYCLES - 1);
            w_state = S_WAIT_ACK;
          end
        end else begin
          w_timer = r_timer - TW'(1);
          if (io_bus.coin_sensed) w_sensed = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        // A sense in the final waiting cycle still counts as a coin.
        if (io_bus.coin_sensed) begin
          w_remaining = r_remaining - r_denom;
          w_coins     = r_coins + 7'd1;
          w_timer     = TW'(GAP_CYCLES - 1);
          w_state     = S_GAP;
        end else if (r_timer == '0) begin
          w_state = S_FAULT;
        end else begin
          w_timer = r_timer - TW'(1);
        end
      end
      S_GAP: begin
        if (r_timer == '0) begin
          w_state = (r_remaining == 7'd0) ? S_DONE : S_SELECT;
        end else begin
          w_timer = r_timer - TW'(1);
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_FAULT: if (io_bus.fault_clr) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_sel       <= 4'b0000;
      r_denom     <= 7'd0;
      r_sensed    <= 1'b0;
      r_remaining <= 7'd0;
      r_coins     <= 7'd0;
      r_eject     <= 4'b0000;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_sel       <= w_sel;
      r_denom     <= w_denom;
      r_sensed    <= w_sensed;
      r_remaining <= w_remaining;
      r_coins     <= w_coins;
      r_eject     <= (w_state == S_EJECT) ? w_sel : 4'b0000;
      r_done      <= (w_state == S_DONE);
      r_fault     <= (w_state == S_FAULT);
      r_busy      <= (w_state != S_IDLE);
    end
  end

  assign io_bus.eject      = r_eject;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.fault      = r_fault;
  assign io_bus.remaining  = r_remaining;
  assign io_bus.coins_paid = r_coins;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed payouts plus randomized amounts,
// empty hoppers and sensor delays, compared with a payout-level model.
module tb_change_dispenser;
  localparam int P     = 2;
  localparam int G     = 2;
  localparam int T     = 8;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst;

  change_dispenser_if bus ();

  change_dispenser #(
    .PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-coin sensor delay (cycles after eject rises) and duplicate-pulse flag.
  int kd [128];
  bit dup [128];

  int exp_d[$], exp_t[$], obs_d[$], obs_t[$];
  int exp_end_cyc, exp_rem, exp_paid;
  bit exp_fault;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int denom_of(input logic [3:0] ej);
    case (ej)
      4'b1000: return 10;
      4'b0100: return 5;
      4'b0010: return 2;
      4'b0001: return 1;
      default: return -1;
    endcase
  endfunction

  // Payout-level model: greedy coin choice and per-coin cycle cost.
  function automatic void model(input int amount, input logic [3:0] empty);
    int rem, paid, t, j, d;
    int denoms [4];
    denoms = '{10, 5, 2, 1};
    rem = amount; paid = 0; t = 1; j = 0;
    exp_d.delete(); exp_t.delete();
    exp_fault = 1'b0;
    while (1) begin
      if (rem == 0) begin exp_end_cyc = t; break; end
      d = 0;
      for (int i = 0; i < 4; i++)
        if (d == 0 && denoms[i] <= rem && !empty[3-i]) d = denoms[i];
      if (d == 0) begin exp_fault = 1'b1; exp_end_cyc = t + 1; break; end
      exp_d.push_back(d);
      exp_t.push_back(t + 1);
      if (kd[j] < P) t = t + 1 + P + G;
      else if (kd[j] < P + T) t = t + 2 + kd[j] + G;
      else begin exp_fault = 1'b1; exp_end_cyc = t + 1 + P + T; break; end
      rem -= d; paid++; j++;
    end
    exp_rem = rem;
    exp_paid = paid;
  endfunction

  task automatic run_payout(input string name, input int amount, input logic [3:0] empty,
                            input bit noise);
    int cyc = 0, idx = 0, sense_at = -1, dup_at = -1, k;
    int end_cyc = -1, end_rem = 0, end_paid = 0, end_busy = 0, hold;
    logic [3:0] prev = 4'b0000;
    bit fin = 1'b0, got_fault = 1'b0;
    model(amount, empty);
    obs_d.delete(); obs_t.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = amount[6:0];
    bus.hopper_empty = empty;
    @(posedge clk);
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.coin_sensed = 1'b0;
      if (bus.eject != 4'b0000 && prev == 4'b0000) begin
        obs_d.push_back(denom_of(bus.eject));
        obs_t.push_back(cyc);
        k = (idx < 128) ? kd[idx] : NEVER;
        sense_at = (k >= NEVER) ? -1 : cyc + k;
        dup_at = (idx < 128 && dup[idx] && sense_at >= 0) ? sense_at + 1 : -1;
        idx++;
      end
      if (cyc == sense_at || cyc == dup_at) bus.coin_sensed = 1'b1;
      prev = bus.eject;
      if (bus.done || bus.fault) begin
        fin = 1'b1;
        got_fault = bus.fault;
        end_cyc = cyc;
        end_rem = bus.remaining;
        end_paid = bus.coins_paid;
        end_busy = bus.busy;
      end else if (noise && bus.busy && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1;
        bus.amount = 7'($urandom_range(1, 127));
      end
    end
    if (!fin) begin
      check_eq({name, " finish"}, 0, 1);
      return;
    end
    check_eq({name, " fault"}, int'(got_fault), int'(exp_fault));
    check_eq({name, " end_cycle"}, end_cyc, exp_end_cyc);
    check_eq({name, " coins_seen"}, obs_d.size(), exp_d.size());
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      check_eq({name, " denom"}, obs_d[i], exp_d[i]);
      check_eq({name, " eject_cycle"}, obs_t[i], exp_t[i]);
    end
    check_eq({name, " remaining"}, end_rem, exp_rem);
    check_eq({name, " coins_paid"}, end_paid, exp_paid);
    check_eq({name, " busy_at_end"}, end_busy, 1);
    if (got_fault) begin
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        bus.coin_sensed = 1'b0;
        check_eq({name, " fault_hold"}, int'(bus.fault), 1);
        check_eq({name, " frozen_rem"}, int'(bus.remaining), exp_rem);
      end
      bus.fault_clr = 1'b1;
    end
    @(negedge clk);
    bus.fault_clr = 1'b0;
    bus.coin_sensed = 1'b0;
    check_eq({name, " idle_busy"}, int'(bus.busy), 0);
    check_eq({name, " idle_done"}, int'(bus.done), 0);
    check_eq({name, " idle_fault"}, int'(bus.fault), 0);
    check_eq({name, " idle_rem"}, int'(bus.remaining), exp_rem);
    check_eq({name, " idle_paid"}, int'(bus.coins_paid), exp_paid);
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, " eject"}, int'(bus.eject), 0);
    check_eq({name, " busy"}, int'(bus.busy), 0);
    check_eq({name, " done"}, int'(bus.done), 0);
    check_eq({name, " fault"}, int'(bus.fault), 0);
    check_eq({name, " remaining"}, int'(bus.remaining), 0);
    check_eq({name, " coins_paid"}, int'(bus.coins_paid), 0);
  endtask

  initial begin
    logic [3:0] emp;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.amount = 7'd0;
    bus.hopper_empty = 4'b0000;
    bus.coin_sensed = 1'b0;
    bus.fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 128; i++) begin kd[i] = 1; dup[i] = 1'b0; end
    run_payout("amt8", 8, 4'b0000, 1'b0);
    run_payout("amt10_no10", 10, 4'b1000, 1'b0);
    run_payout("amt3_no21", 3, 4'b0011, 1'b0);
    kd[0] = NEVER;
    run_payout("amt5_nosense", 5, 4'b0000, 1'b0);
    kd[0] = 1;
    run_payout("amt0", 0, 4'b0000, 1'b0);
    run_payout("amt10_startnoise", 10, 4'b0000, 1'b1);
    kd[0] = P + T - 1; dup[0] = 1'b1;
    run_payout("amt1_lastwait", 1, 4'b0000, 1'b0);
    kd[0] = P + T; dup[0] = 1'b0;
    run_payout("amt1_late", 1, 4'b0000, 1'b0);
    kd[0] = 1;

    // Reset while the first coin of a 10-unit payout is being ejected.
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = 7'd10;
    bus.hopper_empty = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("rst_mid pre_eject", int'(bus.eject), 8);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    run_payout("after_rst", 1, 4'b0000, 1'b0);

    repeat (40) begin
      for (int j = 0; j < 128; j++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) kd[j] = $urandom_range(0, P - 1);
        else kd[j] = P + $urandom_range(0, T - 1);
        dup[j] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 6) == 0) kd[$urandom_range(0, 7)] = NEVER;
      for (int b = 0; b < 4; b++) emp[b] = ($urandom_range(0, 3) == 0);
      run_payout("rnd", $urandom_range(0, 60), emp, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
